// File: rtl/npu_shift_pkg.sv
// Shared definitions for the requantization shift stage: sequencer state
// encoding, default widths and the round-half-up offset helper.
package npu_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEF_IN_WIDTH   = 10;
    localparam int unsigned DEF_IN_S_WIDTH = 3;
    localparam int unsigned DEF_OUT_WIDTH  = 15;
    localparam int unsigned DEF_TAIL_BIT   = 5;
    localparam int unsigned DEF_NUM_CH     = 16;
    localparam int unsigned DEF_LEN_WIDTH  = 16;

    // Half an LSB of the post-shift result, expressed in pre-shift units.
    function automatic logic [31:0] rnd_offset(input logic [7:0] shift);
        if (shift == 8'd0) begin
            return '0;
        end
        return 32'd1 << (shift - 8'd1);
    endfunction

endpackage

// File: rtl/right_shifter.sv
// Combinational widen-and-shift: appends TAIL_BIT zeros below the signed
// input, then arithmetic right shift by in_shift into OUT_WIDTH bits.
// SHIFT_SCHED_RND_EN selects round-half-up with positive saturation;
// otherwise the shift truncates toward -inf.
module right_shifter
    import npu_shift_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned IN_S_WIDTH = DEF_IN_S_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned TAIL_BIT   = DEF_TAIL_BIT
) (
    input  logic signed [IN_WIDTH-1:0]   in_data,
    input  logic        [IN_S_WIDTH-1:0] in_shift,
    output logic signed [OUT_WIDTH-1:0]  out_data
);

    localparam int unsigned WIDE = IN_WIDTH + TAIL_BIT;

    logic signed [WIDE-1:0] widened;

    assign widened = {in_data, {TAIL_BIT{1'b0}}};

`ifdef SHIFT_SCHED_RND_EN
    // One spare bit above OUT_WIDTH so the rounding add cannot wrap.
    localparam int unsigned IW = OUT_WIDTH + 1;
    localparam logic signed [IW-1:0] MAXP = IW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);

    logic signed [IW-1:0] ext_w;
    logic signed [IW-1:0] off_w;
    logic signed [IW-1:0] sum_w;
    logic signed [IW-1:0] shr_w;

    // Round-half-up then saturate positive overflow.
    always_comb begin
        ext_w = IW'(widened);
        off_w = IW'(rnd_offset(8'(in_shift)));
        sum_w = ext_w + off_w;
        shr_w = sum_w >>> in_shift;
        if (shr_w > MAXP) begin
            out_data = OUT_WIDTH'(MAXP);
        end else begin
            out_data = OUT_WIDTH'(shr_w);
        end
    end
`else
    logic signed [OUT_WIDTH-1:0] ext;

    // Sign-extend then truncating arithmetic shift (floors toward -inf).
    always_comb begin
        ext      = OUT_WIDTH'(widened);
        out_data = ext >>> in_shift;
    end
`endif

endmodule

// File: rtl/shift_sched.sv
// Requantization stream sequencer: per-channel shift table, channel/beat
// counters, IDLE/RUN/DRAIN control and a single output register with
// pass-through acceptance. Optional rounding via SHIFT_SCHED_RND_EN
// (handled inside right_shifter).
module shift_sched
    import npu_shift_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned IN_S_WIDTH = DEF_IN_S_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned TAIL_BIT   = DEF_TAIL_BIT,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]   i_cfg_idx,
    input  logic [IN_S_WIDTH-1:0]       i_cfg_shift,
    input  logic                        i_start,
    input  logic [$clog2(NUM_CH)-1:0]   i_ch_last,
    input  logic [LEN_WIDTH-1:0]        i_len,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_cfg_err,
    input  logic                        i_valid,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic [$clog2(NUM_CH)-1:0]   o_ch,
    output logic                        o_last,
    input  logic                        i_out_ready
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    state_t                      state;
    state_t                      state_nx;
    logic [IN_S_WIDTH-1:0]       shift_tab [NUM_CH];
    logic [CH_W-1:0]             ch;
    logic [CH_W-1:0]             ch_last_r;
    logic [LEN_WIDTH-1:0]        cnt;
    logic [LEN_WIDTH-1:0]        len_r;
    logic                        accept;
    logic                        beat_last;
    logic                        drained;
    logic signed [OUT_WIDTH-1:0] sh_out;

    assign o_busy    = (state != IDLE);
    assign o_ready   = (state == RUN) && (!o_valid || i_out_ready);
    assign accept    = i_valid && o_ready;
    assign beat_last = (cnt == len_r);
    assign drained   = !o_valid || i_out_ready;

    right_shifter #(
        .IN_WIDTH   (IN_WIDTH),
        .IN_S_WIDTH (IN_S_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .TAIL_BIT   (TAIL_BIT)
    ) u_shifter (
        .in_data  (i_data),
        .in_shift (shift_tab[ch]),
        .out_data (sh_out)
    );

    // Next-state selection for the burst sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start)              state_nx = RUN;
            RUN:     if (accept && beat_last)  state_nx = DRAIN;
            DRAIN:   if (drained)              state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    // State register plus done pulse and sticky config-error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_done    <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= (state == DRAIN) && drained;
            if ((state != IDLE) && (i_cfg_we || i_start)) begin
                o_cfg_err <= 1'b1;
            end
        end
    end

    // Shift table; writes only land while idle, so a same-cycle start sees them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shift_tab[i] <= '0;
            end
        end else if ((state == IDLE) && i_cfg_we) begin
            shift_tab[i_cfg_idx] <= i_cfg_shift;
        end
    end

    // Burst parameters latched at start; channel and beat counters per accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch_last_r <= '0;
            len_r     <= '0;
            ch        <= '0;
            cnt       <= '0;
        end else if ((state == IDLE) && i_start) begin
            ch_last_r <= i_ch_last;
            len_r     <= i_len;
            ch        <= '0;
            cnt       <= '0;
        end else if (accept) begin
            cnt <= cnt + LEN_WIDTH'(1);
            if (ch == ch_last_r) begin
                ch <= '0;
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    // Output register: load on accept, empty when downstream takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_data  <= sh_out;
            o_ch    <= ch;
            o_last  <= beat_last;
        end else if (i_out_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched. Inputs change on the falling
// edge and outputs are sampled there, half a cycle away from the active edge.
module tb_shift_sched;

    logic               clk;
    logic               rst_n;
    logic               cfg_we;
    logic [3:0]         cfg_idx;
    logic [2:0]         cfg_shift;
    logic               start;
    logic [3:0]         ch_last;
    logic [15:0]        len;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic               valid;
    logic signed [9:0]  data;
    logic               ready;
    logic               out_valid;
    logic signed [14:0] out_data;
    logic [3:0]         out_ch;
    logic               out_last;
    logic               out_ready;

    int total = 0;
    int bad   = 0;

`ifdef SHIFT_SCHED_RND_EN
    localparam int EXP_POS3 = 1;
`else
    localparam int EXP_POS3 = 0;
`endif

    shift_sched #(
        .IN_WIDTH   (10),
        .IN_S_WIDTH (3),
        .OUT_WIDTH  (15),
        .TAIL_BIT   (5),
        .NUM_CH     (16),
        .LEN_WIDTH  (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_we    (cfg_we),
        .i_cfg_idx   (cfg_idx),
        .i_cfg_shift (cfg_shift),
        .i_start     (start),
        .i_ch_last   (ch_last),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_cfg_err   (cfg_err),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_ch        (out_ch),
        .o_last      (out_last),
        .i_out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int d, input int c, input int l);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".data"},  32'(out_data),  d);
        chk({tag, ".ch"},    32'(out_ch),    c);
        chk({tag, ".last"},  32'(out_last),  l);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".busy"},    32'(busy),      0);
        chk({tag, ".done"},    32'(done),      0);
        chk({tag, ".cfg_err"}, 32'(cfg_err),   0);
        chk({tag, ".ready"},   32'(ready),     0);
        chk({tag, ".valid"},   32'(out_valid), 0);
        chk({tag, ".data"},    32'(out_data),  0);
        chk({tag, ".ch"},      32'(out_ch),    0);
        chk({tag, ".last"},    32'(out_last),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_shift = '0;
        start = 1'b0; ch_last = '0; len = '0; valid = 1'b0; data = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_chk("reset");
        rst_n = 1'b1;

        // table[0]=2, table[1]=5, then table[1]=0 together with start
        @(negedge clk); cfg_we = 1'b1; cfg_idx = 4'd0; cfg_shift = 3'd2;
        @(negedge clk); cfg_idx = 4'd1; cfg_shift = 3'd5;
        @(negedge clk); cfg_idx = 4'd1; cfg_shift = 3'd0;
        start = 1'b1; ch_last = 4'd1; len = 16'd3;
        @(negedge clk); cfg_we = 1'b0; start = 1'b0;
        chk("a.busy", 32'(busy), 1);
        chk("a.ready", 32'(ready), 1);
        chk("a.valid0", 32'(out_valid), 0);
        valid = 1'b1; data = -10'sd3;
        @(negedge clk); beat("a.b0", -24, 0, 0);
        data = 10'sd5;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_shift = 3'd7; start = 1'b1;
        @(negedge clk); beat("a.b1", 160, 1, 0);
        chk("a.cfg_err", 32'(cfg_err), 1);
        cfg_we = 1'b0; start = 1'b0; data = 10'sd7; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); beat("a.stall", 160, 1, 0);
            chk("a.stall.ready", 32'(ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk); beat("a.b2", 56, 0, 0);
        data = -10'sd1;
        @(negedge clk); beat("a.b3", -32, 1, 1);
        chk("a.drain.ready", 32'(ready), 0);
        chk("a.drain.busy", 32'(busy), 1);
        chk("a.drain.done", 32'(done), 0);
        valid = 1'b0;
        @(negedge clk);
        chk("a.done", 32'(done), 1);
        chk("a.idle.busy", 32'(busy), 0);
        chk("a.idle.valid", 32'(out_valid), 0);
        chk("a.err_sticky", 32'(cfg_err), 1);

        // back-to-back burst, ch_last=0, table[0] still 2
        start = 1'b1; ch_last = 4'd0; len = 16'd2;
        @(negedge clk); start = 1'b0;
        chk("b.done_pulse", 32'(done), 0);
        chk("b.busy", 32'(busy), 1);
        valid = 1'b1; data = 10'sd100;
        @(negedge clk); beat("b.b0", 800, 0, 0);
        chk("b.ready", 32'(ready), 1);
        data = -10'sd100;
        @(negedge clk); beat("b.b1", -800, 0, 0);
        data = 10'sd511;
        @(negedge clk); beat("b.b2", 4088, 0, 1);
        valid = 1'b0;
        @(negedge clk); chk("b.done", 32'(done), 1);

        // shift 7, one-beat bursts: +3 and -3
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_shift = 3'd7;
        @(negedge clk); cfg_we = 1'b0; start = 1'b1; len = 16'd0; ch_last = 4'd0;
        @(negedge clk); start = 1'b0; valid = 1'b1; data = 10'sd3;
        @(negedge clk); beat("c.pos3", EXP_POS3, 0, 1);
        valid = 1'b0;
        @(negedge clk); chk("c.done", 32'(done), 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0; valid = 1'b1; data = -10'sd3;
        @(negedge clk); beat("c.neg3", -1, 0, 1);
        valid = 1'b0;
        @(negedge clk); chk("c.done2", 32'(done), 1);

        // reset mid-burst
        start = 1'b1; len = 16'd5; ch_last = 4'd3;
        @(negedge clk); start = 1'b0; valid = 1'b1; data = 10'sd1;
        @(negedge clk); chk("d.valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1 rst_chk("d.rst");
        @(negedge clk); rst_chk("d.rst_hold");
        valid = 1'b0; rst_n = 1'b1;
        @(negedge clk); chk("d.idle", 32'(busy), 0);
        start = 1'b1; len = 16'd0; ch_last = 4'd0;
        @(negedge clk); start = 1'b0;
        chk("d.busy", 32'(busy), 1);
        valid = 1'b1; data = 10'sd1;
        @(negedge clk); beat("d.b0", 32, 0, 1);
        valid = 1'b0;
        @(negedge clk);
        chk("d.done", 32'(done), 1);
        chk("d.cfg_err", 32'(cfg_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
# shift_sched

Stream sequencer for the requantization right-shift stage. It holds a per-channel shift table and walks an output-channel counter over a burst of accumulator beats. It applies the selected shift through a `right_shifter` instance and delivers scaled results downstream with valid/ready backpressure. It sits between the PE accumulator drain and the activation/writeback path, and is configured by the layer controller before each burst.

## Interface
- IN_WIDTH, 10, signed input sample width
- IN_S_WIDTH, 3, shift amount width (shift 0..7)
- OUT_WIDTH, 15, signed output width
- TAIL_BIT, 5, zero bits appended below input before shift
- NUM_CH, 16, shift table depth (channels)
- LEN_WIDTH, 16, burst length counter width
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cfg_we  in  1  shift table write strobe
- i_cfg_idx  in  $clog2(NUM_CH)  table write index
- i_cfg_shift  in  IN_S_WIDTH  shift value written
- i_start  in  1  burst start pulse
- i_ch_last  in  $clog2(NUM_CH)  last channel index; counter wraps after it
- i_len  in  LEN_WIDTH  beats in burst, minus one
- o_busy  out  1  FSM not IDLE
- o_done  out  1  one-cycle pulse at burst completion
- o_cfg_err  out  1  sticky: write or start rejected while busy
- i_valid  in  1  input beat valid
- i_data  in  IN_WIDTH  signed accumulator beat
- o_ready  out  1  input accept
- o_valid  out  1  output beat valid
- o_data  out  OUT_WIDTH  scaled result
- o_ch  out  $clog2(NUM_CH)  channel index of o_data
- o_last  out  1  final beat of burst
- i_out_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - i_cfg_we writes table[i_cfg_idx].
  - i_start latches i_ch_last and i_len, clears the channel counter and beat counter, then goes to RUN.
  - If i_cfg_we and i_start arrive together: the write lands first, so the burst sees the new value.
- RUN:
  - A beat is accepted on i_valid && o_ready.
  - On each accepted beat:
    - o_data = ({i_data, TAIL_BIT zeros} >>> table[ch]), sign-extended to OUT_WIDTH.
    - o_ch = ch.
    - o_last = (beat count == len).
  - ch increments per accepted beat and wraps to 0 after ch_last.
  - Accepting the beat with count == len moves the FSM to DRAIN.
- DRAIN: when the output register empties (o_valid low, or o_valid && i_out_ready), pulse o_done and return to IDLE.
- Rejections:
  - i_cfg_we or i_start outside IDLE is ignored and sets o_cfg_err.
  - o_cfg_err clears only on reset.
- o_ready = (state==RUN) && (!o_valid || i_out_ready), i.e. a single output register with pass-through acceptance, no bubbles.
- Arithmetic shift floors toward −inf.
- Shift table resets to all zero.

## Timing
- Reset values: o_busy 0, o_done 0, o_cfg_err 0, o_ready 0, o_valid 0, o_data 0, o_ch 0, o_last 0. Reset mid-burst aborts immediately, with no o_done.
- Latency 1 cycle: a beat accepted at edge N appears on o_valid after edge N.
- Output is held stable while o_valid && !i_out_ready.
- Full throughput is one beat per cycle when i_out_ready is held high.
- o_busy rises the cycle after i_start.
- o_done asserts in the cycle after the o_last beat is taken; o_busy drops on that same edge.
- i_len = 0 gives a one-beat burst.
- i_ch_last = 0 gives ch constant at 0.

## Configuration
- SHIFT_SCHED_RND_EN defined:
  - Round-half-up. Add 1<<(shift−1) to the widened value before the shift when shift>0.
  - Intermediate is OUT_WIDTH+1 bits; results above the max positive value saturate to 2^(OUT_WIDTH−1)−1.
  - Latency is unchanged.
- SHIFT_SCHED_RND_EN undefined: plain truncating arithmetic shift as above.

## Structure
- The shared package `npu_shift_pkg` holds:
  - the state enum typedef (IDLE/RUN/DRAIN)
  - default width localparams
  - the rounding-offset helper function
- The one natural sub-module is the existing `right_shifter`, fed the table-selected shift amount.
- The table, counters, FSM and output register stay in `shift_sched`.

## Test plan
- Reset, then write table[0]=2 and table[1]=0. Start with ch_last=1, len=3 and data −3, 5, 7, −1. Required output: −24, 160, 56, −32; o_ch 0,1,0,1; o_last on the 4th beat; o_done one cycle later.
- Hold i_out_ready=0 for 3 cycles mid-burst → o_data/o_ch stable, o_ready=0, no beats lost or duplicated.
- i_cfg_we and i_start during RUN → ignored, o_cfg_err=1, burst unaffected.
- Write table[0]=7, len=0, data 3 → o_data 0 without rounding; 1 with SHIFT_SCHED_RND_EN. Data −3 → −1 in both builds.
- Assert i_rst_n low mid-burst → all outputs return to reset values, o_done never pulses, FSM returns to IDLE and a new start is accepted.
- Back-to-back bursts: i_start in the cycle after o_done → second burst runs at full throughput, with ch restarting at 0.
